// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, access-size
// codes, the default IO address window tag and the LSB starvation limit.
package mem_pkg;

    // FSM state encoding
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_IO_WAIT = 2'd3;

    // ls_size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // addr[17:16] tag that marks the IO window
    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    // consecutive LSB grants allowed while I-fetch is waiting
    localparam logic [1:0] STARVE_LIMIT = 2'd2;

    // number of bytes moved for a given ls_size code
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between the I-fetch unit and the load/store buffer in
// front of an 8-bit synchronous RAM (1-cycle read latency). Multi-byte
// accesses are serialized little-endian; stores into the IO window wait for
// room in the UART buffer. A low rdy_in freezes the whole block in place, so
// the byte in flight is simply driven again once rdy_in returns.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        clear_in,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    logic [1:0]  state_r;
    logic [1:0]  grant_cnt_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  len_r;
    logic [2:0]  cnt_r;
    logic        is_ic_r;
    logic [31:0] buf_r;
    logic [31:0] mem_a_r;
    logic [7:0]  mem_dout_r;
    logic        mem_wr_r;
    logic        ic_valid_r;
    logic [31:0] ic_data_r;
    logic        ls_done_r;
    logic [31:0] ls_rdata_r;

    logic        ic_ok_s;
    logic        ls_first_s;
    logic        grant_ls_s;
    logic        grant_ic_s;
    logic        io_hit_s;
    logic [31:0] acc_addr_s;
    logic [2:0]  acc_len_s;
    logic [2:0]  next_off_s;
    logic [31:0] next_addr_s;
    logic [7:0]  wbyte_s;
    logic [31:0] assembled_s;

    // Arbitration, operand selection and byte-lane datapath
    always_comb begin
        ic_ok_s    = ic_req && !clear_in;
        // LSB wins unless it has already taken STARVE_LIMIT grants in a row
        ls_first_s = ls_req && !(ic_ok_s && (grant_cnt_r == STARVE_LIMIT));
        grant_ls_s = 1'b0;
        grant_ic_s = 1'b0;
        if (state_r == S_IDLE) begin
            grant_ls_s = ls_first_s;
            grant_ic_s = ic_ok_s && !ls_first_s;
        end else begin
            grant_ls_s = 1'b0;
            grant_ic_s = 1'b0;
        end
        io_hit_s = (ls_addr[17:16] == IO_HI);
        if (grant_ic_s) begin
            acc_addr_s = ic_addr;
            acc_len_s  = 3'd4;
        end else if (!ls_we && io_hit_s) begin
            // IO loads are always a single byte
            acc_addr_s = ls_addr;
            acc_len_s  = 3'd1;
        end else begin
            acc_addr_s = ls_addr;
            acc_len_s  = size_to_len(ls_size);
        end
        next_off_s  = cnt_r + 3'd1;
        next_addr_s = addr_r + {29'd0, next_off_s};
        wbyte_s     = 8'(wdata_r >> {next_off_s, 3'b000});
        // byte returned now belongs to the address issued one cycle earlier
        assembled_s = buf_r | ({24'd0, mem_din} << {cnt_r - 3'd1, 3'b000});
    end

    // Transaction FSM, grant counter and all registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= S_IDLE;
            grant_cnt_r <= 2'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            len_r       <= 3'd0;
            cnt_r       <= 3'd0;
            is_ic_r     <= 1'b0;
            buf_r       <= 32'd0;
            mem_a_r     <= 32'd0;
            mem_dout_r  <= 8'd0;
            mem_wr_r    <= 1'b0;
            ic_valid_r  <= 1'b0;
            ic_data_r   <= 32'd0;
            ls_done_r   <= 1'b0;
            ls_rdata_r  <= 32'd0;
        end else if (rdy_in) begin
            ic_valid_r <= 1'b0;
            ls_done_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (grant_ic_s || grant_ls_s) begin
                        addr_r  <= acc_addr_s;
                        wdata_r <= ls_wdata;
                        len_r   <= acc_len_s;
                        cnt_r   <= 3'd0;
                        is_ic_r <= grant_ic_s;
                        buf_r   <= 32'd0;
                        if (grant_ic_s) begin
                            grant_cnt_r <= 2'd0;
                        end else if (grant_cnt_r < STARVE_LIMIT) begin
                            grant_cnt_r <= grant_cnt_r + 2'd1;
                        end else begin
                            grant_cnt_r <= grant_cnt_r;
                        end
                        if (grant_ls_s && ls_we) begin
                            if (io_hit_s && io_buffer_full) begin
                                state_r <= S_IO_WAIT;
                            end else begin
                                state_r    <= S_WRITE;
                                mem_a_r    <= acc_addr_s;
                                mem_dout_r <= ls_wdata[7:0];
                                mem_wr_r   <= 1'b1;
                            end
                        end else begin
                            state_r <= S_READ;
                            mem_a_r <= acc_addr_s;
                        end
                    end
                end
                S_READ: begin
                    if (is_ic_r && clear_in) begin
                        state_r <= S_IDLE;
                    end else begin
                        if (cnt_r != 3'd0) begin
                            buf_r <= assembled_s;
                        end
                        if (cnt_r == len_r) begin
                            state_r <= S_IDLE;
                            if (is_ic_r) begin
                                ic_valid_r <= 1'b1;
                                ic_data_r  <= assembled_s;
                            end else begin
                                ls_done_r  <= 1'b1;
                                ls_rdata_r <= assembled_s;
                            end
                        end else begin
                            cnt_r <= next_off_s;
                            if (next_off_s < len_r) begin
                                mem_a_r <= next_addr_s;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (next_off_s < len_r) begin
                        mem_a_r    <= next_addr_s;
                        mem_dout_r <= wbyte_s;
                        mem_wr_r   <= 1'b1;
                        cnt_r      <= next_off_s;
                    end else begin
                        mem_wr_r  <= 1'b0;
                        ls_done_r <= 1'b1;
                        state_r   <= S_IDLE;
                    end
                end
                S_IO_WAIT: begin
                    if (!io_buffer_full) begin
                        mem_a_r    <= addr_r;
                        mem_dout_r <= wdata_r[7:0];
                        mem_wr_r   <= 1'b1;
                        state_r    <= S_WRITE;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    mem_wr_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_a    = mem_a_r;
    assign mem_dout = mem_dout_r;
    // a frozen cycle must never repeat a write strobe into RAM
    assign mem_wr   = mem_wr_r & rdy_in;
    assign ic_valid = ic_valid_r;
    assign ic_data  = ic_data_r;
    assign ls_done  = ls_done_r;
    assign ls_rdata = ls_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-wide synchronous RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_in, rdy_in;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full, clear_in;
    logic        ic_req, ic_valid;
    logic [31:0] ic_addr, ic_data;
    logic        ls_req, ls_we, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;

    int checks;
    int errors;

    logic [7:0]  ram [0:262143];
    logic        pre_en;
    logic [17:0] pre_addr;
    logic [7:0]  pre_data;

    mem_arbiter dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .clear_in(clear_in),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_data(ic_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    // RAM shares the global ready: it stalls together with the arbiter
    always @(posedge clk) begin
        if (rdy_in) mem_din <= ram[mem_a[17:0]];
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end

    task automatic preset(input logic [17:0] a, input logic [7:0] d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic load_ram;
        preset(18'h00100, 8'h11); preset(18'h00101, 8'h22);
        preset(18'h00102, 8'h33); preset(18'h00103, 8'h44);
        preset(18'h00206, 8'h77); preset(18'h00010, 8'h5A);
        preset(18'h00020, 8'h01); preset(18'h00021, 8'h02);
        preset(18'h00022, 8'h03); preset(18'h00023, 8'h04);
        preset(18'h30010, 8'h9C); preset(18'h30011, 8'h11);
        preset(18'h00040, 8'hC3); preset(18'h01000, 8'hAA);
        preset(18'h01001, 8'hBB); preset(18'h01002, 8'hCC);
        preset(18'h01003, 8'hDD);
    endtask

    task automatic test_reset;
        // reset held with rdy_in low: reset must still win
        @(negedge clk); @(negedge clk);
        checks++; if (mem_a !== 32'd0) begin errors++; $display("FAIL reset_mem_a got %h exp %h", mem_a, 32'd0); end
        checks++; if (mem_dout !== 8'd0) begin errors++; $display("FAIL reset_mem_dout got %h exp %h", mem_dout, 8'd0); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
        checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL reset_ic_valid got %b exp 0", ic_valid); end
        checks++; if (ic_data !== 32'd0) begin errors++; $display("FAIL reset_ic_data got %h exp %h", ic_data, 32'd0); end
        checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL reset_ls_done got %b exp 0", ls_done); end
        checks++; if (ls_rdata !== 32'd0) begin errors++; $display("FAIL reset_ls_rdata got %h exp %h", ls_rdata, 32'd0); end
        rst_in = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic test_word_load;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (mem_a !== 32'h100 + 32'(i) || mem_wr !== 1'b0) begin errors++; $display("FAIL wload_addr%0d got %h/%b exp %h/0", i, mem_a, mem_wr, 32'h100 + 32'(i)); end
        end
        @(negedge clk);
        checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL wload_early_done got %b exp 0", ls_done); end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || ls_rdata !== 32'h44332211) begin errors++; $display("FAIL wload_done got %b/%h exp 1/44332211", ls_done, ls_rdata); end
        ls_req = 1'b0;
        @(negedge clk);
        checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL wload_pulse got %b exp 0", ls_done); end
    endtask

    task automatic test_half_store;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h204; ls_wdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h204 || mem_dout !== 8'hEF) begin errors++; $display("FAIL hstore_b0 got %b/%h/%h exp 1/204/ef", mem_wr, mem_a, mem_dout); end
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h205 || mem_dout !== 8'hBE) begin errors++; $display("FAIL hstore_b1 got %b/%h/%h exp 1/205/be", mem_wr, mem_a, mem_dout); end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || mem_wr !== 1'b0 || mem_a !== 32'h205) begin errors++; $display("FAIL hstore_done got %b/%b/%h exp 1/0/205", ls_done, mem_wr, mem_a); end
        ls_req = 1'b0;
        @(negedge clk);
        checks++; if (ram[18'h204] !== 8'hEF || ram[18'h205] !== 8'hBE || ram[18'h206] !== 8'h77) begin errors++; $display("FAIL hstore_ram got %h %h %h exp ef be 77", ram[18'h204], ram[18'h205], ram[18'h206]); end
    endtask

    task automatic test_io_store;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h000000A5;
        io_buffer_full = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL io_wait_wr%0d got %b exp 0", i, mem_wr); end
            if (i == 5) io_buffer_full = 1'b0;
        end
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'hA5) begin errors++; $display("FAIL io_write got %b/%h/%h exp 1/30000/a5", mem_wr, mem_a, mem_dout); end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL io_done got %b/%b exp 1/0", ls_done, mem_wr); end
        ls_req = 1'b0;
        @(negedge clk);
        checks++; if (ram[18'h30000] !== 8'hA5) begin errors++; $display("FAIL io_ram got %h exp a5", ram[18'h30000]); end
    endtask

    task automatic test_io_load;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h30010;
        @(negedge clk);
        checks++; if (mem_a !== 32'h30010) begin errors++; $display("FAIL ioload_a0 got %h exp 30010", mem_a); end
        @(negedge clk);
        checks++; if (mem_a !== 32'h30010 || ls_done !== 1'b0) begin errors++; $display("FAIL ioload_a1 got %h/%b exp 30010/0", mem_a, ls_done); end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || ls_rdata !== 32'h0000009C) begin errors++; $display("FAIL ioload_done got %b/%h exp 1/0000009c", ls_done, ls_rdata); end
        ls_req = 1'b0;
    endtask

    task automatic test_wrap;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'hFFFFFFFF; ls_wdata = 32'h00003412;
        @(negedge clk);
        checks++; if (mem_a !== 32'hFFFFFFFF || mem_dout !== 8'h12 || mem_wr !== 1'b1) begin errors++; $display("FAIL wrap_b0 got %h/%h/%b exp ffffffff/12/1", mem_a, mem_dout, mem_wr); end
        @(negedge clk);
        checks++; if (mem_a !== 32'h0 || mem_dout !== 8'h34 || mem_wr !== 1'b1) begin errors++; $display("FAIL wrap_b1 got %h/%h/%b exp 00000000/34/1", mem_a, mem_dout, mem_wr); end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", ls_done); end
        ls_req = 1'b0;
        @(negedge clk);
        checks++; if (ram[18'h3FFFF] !== 8'h12 || ram[18'h0] !== 8'h34) begin errors++; $display("FAIL wrap_ram got %h %h exp 12 34", ram[18'h3FFFF], ram[18'h0]); end
    endtask

    task automatic test_fairness;
        int n;
        logic got_ic;
        @(negedge clk); rst_in = 1'b1;
        @(negedge clk); rst_in = 1'b0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h10;
        ic_req = 1'b1; ic_addr = 32'h20;
        n = 0;
        for (int c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            if (ls_done === 1'b1 || ic_valid === 1'b1) begin
                got_ic = ic_valid;
                checks++; if (got_ic !== ((n % 3) == 2) || (ls_done & ic_valid) === 1'b1) begin errors++; $display("FAIL grant_order%0d got ic=%b ls=%b exp ic=%b", n, ic_valid, ls_done, ((n % 3) == 2)); end
                if (got_ic) begin
                    checks++; if (ic_data !== 32'h04030201) begin errors++; $display("FAIL fetch_data got %h exp 04030201", ic_data); end
                end else begin
                    checks++; if (ls_rdata !== 32'h0000005A) begin errors++; $display("FAIL byte_load_data got %h exp 0000005a", ls_rdata); end
                end
                n++;
                if (n == 6) begin ls_req = 1'b0; ic_req = 1'b0; end
            end
        end
        ls_req = 1'b0; ic_req = 1'b0;
        checks++; if (n != 6) begin errors++; $display("FAIL grant_timeout got %0d grants exp 6", n); end
    endtask

    task automatic test_clear_fetch;
        // clear in IDLE suppresses a fetch accept
        @(negedge clk);
        ic_req = 1'b1; ic_addr = 32'h1000; clear_in = 1'b1;
        @(negedge clk);
        checks++; if (mem_a !== 32'h23) begin errors++; $display("FAIL clear_idle0 got %h exp 23", mem_a); end
        @(negedge clk);
        checks++; if (mem_a !== 32'h23 || ic_valid !== 1'b0) begin errors++; $display("FAIL clear_idle1 got %h/%b exp 23/0", mem_a, ic_valid); end
        clear_in = 1'b0;
        @(negedge clk);
        checks++; if (mem_a !== 32'h1000) begin errors++; $display("FAIL fetch_a0 got %h exp 1000", mem_a); end
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h40;
        @(negedge clk);
        checks++; if (mem_a !== 32'h1001) begin errors++; $display("FAIL fetch_a1 got %h exp 1001", mem_a); end
        @(negedge clk);
        checks++; if (mem_a !== 32'h1002) begin errors++; $display("FAIL fetch_a2 got %h exp 1002", mem_a); end
        clear_in = 1'b1; ic_req = 1'b0;
        @(negedge clk);
        checks++; if (ic_valid !== 1'b0) begin errors++; $display("FAIL abort_valid0 got %b exp 0", ic_valid); end
        clear_in = 1'b0;
        @(negedge clk);
        checks++; if (mem_a !== 32'h40 || ic_valid !== 1'b0) begin errors++; $display("FAIL abort_ls_accept got %h/%b exp 40/0", mem_a, ic_valid); end
        @(negedge clk);
        checks++; if (ic_valid !== 1'b0 || ls_done !== 1'b0) begin errors++; $display("FAIL abort_valid1 got %b/%b exp 0/0", ic_valid, ls_done); end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || ls_rdata !== 32'h000000C3 || ic_valid !== 1'b0) begin errors++; $display("FAIL abort_ls_done got %b/%h/%b exp 1/000000c3/0", ls_done, ls_rdata, ic_valid); end
        ls_req = 1'b0;
    endtask

    task automatic test_stall;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h100;
        @(negedge clk);
        checks++; if (mem_a !== 32'h100) begin errors++; $display("FAIL stall_a0 got %h exp 100", mem_a); end
        @(negedge clk);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_a !== 32'h101 || mem_wr !== 1'b0 || ls_done !== 1'b0 || ls_rdata !== 32'h000000C3) begin errors++; $display("FAIL stall_frozen%0d got %h/%b/%b/%h exp 101/0/0/000000c3", i, mem_a, mem_wr, ls_done, ls_rdata); end
            if (i == 2) rdy_in = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL stall_early_done%0d got %b exp 0", i, ls_done); end
        end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1 || ls_rdata !== 32'h44332211) begin errors++; $display("FAIL stall_done got %b/%h exp 1/44332211", ls_done, ls_rdata); end
        ls_req = 1'b0;
        @(negedge clk);
        checks++; if (ls_done !== 1'b0) begin errors++; $display("FAIL stall_pulse got %b exp 0", ls_done); end
        // stall in the middle of a word store
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h300; ls_wdata = 32'h0A0B0C0D;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h300 || mem_dout !== 8'h0D) begin errors++; $display("FAIL sstall_b0 got %b/%h/%h exp 1/300/0d", mem_wr, mem_a, mem_dout); end
        @(negedge clk);
        rdy_in = 1'b0;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL sstall_wr0 got %b exp 0", mem_wr); end
        @(negedge clk);
        checks++; if (mem_wr !== 1'b0 || mem_a !== 32'h301) begin errors++; $display("FAIL sstall_wr1 got %b/%h exp 0/301", mem_wr, mem_a); end
        rdy_in = 1'b1;
        @(negedge clk);
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h302 || mem_dout !== 8'h0B) begin errors++; $display("FAIL sstall_b2 got %b/%h/%h exp 1/302/0b", mem_wr, mem_a, mem_dout); end
        @(negedge clk);
        checks++; if (mem_a !== 32'h303 || mem_dout !== 8'h0A) begin errors++; $display("FAIL sstall_b3 got %h/%h exp 303/0a", mem_a, mem_dout); end
        @(negedge clk);
        checks++; if (ls_done !== 1'b1) begin errors++; $display("FAIL sstall_done got %b exp 1", ls_done); end
        ls_req = 1'b0;
        @(negedge clk);
        checks++; if (ram[18'h300] !== 8'h0D || ram[18'h301] !== 8'h0C || ram[18'h302] !== 8'h0B || ram[18'h303] !== 8'h0A) begin errors++; $display("FAIL sstall_ram got %h %h %h %h exp 0d 0c 0b 0a", ram[18'h300], ram[18'h301], ram[18'h302], ram[18'h303]); end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        rst_in = 1'b0;
        checks++; if (mem_a !== 32'd0 || ls_rdata !== 32'd0 || ls_done !== 1'b0) begin errors++; $display("FAIL abort_reset got %h/%h/%b exp 0/0/0", mem_a, ls_rdata, ls_done); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (ls_done !== 1'b0 || mem_a !== 32'd0) begin errors++; $display("FAIL abort_quiet%0d got %b/%h exp 0/0", i, ls_done, mem_a); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst_in = 1'b1; rdy_in = 1'b0;
        io_buffer_full = 1'b0; clear_in = 1'b0;
        ic_req = 1'b0; ic_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
        pre_en = 1'b0; pre_addr = 18'd0; pre_data = 8'd0;
        load_ram;
        test_reset;
        test_word_load;
        test_half_store;
        test_io_store;
        test_io_load;
        test_wrap;
        test_fairness;
        test_clear_fetch;
        test_stall;
        test_reset_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
